// File: rtl/stream_test_seq.sv
// stream_test_seq
// ---------------
// Sequencer for the SDRAM stream test. It writes one pass of incrementing
// 32-bit words to the SDRAM write path as 16-bit halves (high half first).
// It waits a fixed drain gap and then reads the pass back. Each word is
// rebuilt from its two read halves and compared with the expected value.
// Every read half is also forwarded to the downstream stream error checker.
//
// Optional feature macro: STREAM_SEQ_FIRST_ERR_EN
//   defined   : first_err_idx / first_err_word capture the index and the
//               received value of the first mismatch since start.
//   undefined : both ports are tied to 0 and no capture registers exist.
//
// Parameters
//   WORDS    32-bit words per pass (1..65535)
//   SEED     first pattern word after start
//   GAP_CYC  idle cycles between the write and read phases (0 allowed)
//   ERR_W    width of err_cnt
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, loop, abort  control (abort has priority over everything)
//   wr_data/wr_valid/wr_ready   write-path half-word handshake
//   rd_en, rd_data, rd_valid    read path (rd_valid accepted every cycle)
//   chk_data, chk_wren  registered copy of the read stream for the checker
//   busy, done          status; done pulses once per completed pass
//   pass_cnt, err_cnt, err_flag  pass/error statistics
//   first_err_idx, first_err_word  first-mismatch capture (optional)

module stream_test_seq #(
  parameter int unsigned WORDS   = 1024,
  parameter logic [31:0] SEED    = 32'h0000_0000,
  parameter int unsigned GAP_CYC = 16,
  parameter int unsigned ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             loop,
  input  logic             abort,
  output logic [15:0]      wr_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             rd_en,
  input  logic [15:0]      rd_data,
  input  logic             rd_valid,
  output logic [15:0]      chk_data,
  output logic             chk_wren,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pass_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [15:0]      first_err_idx,
  output logic [31:0]      first_err_word
);

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;

  localparam logic [15:0] LAST_IDX   = 16'(WORDS - 1);
  localparam logic [31:0] WORDS32    = 32'(WORDS);
  localparam int          GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];

  state_t             state;
  state_t             state_next;
  logic [31:0]        base;
  logic [15:0]        wr_idx;
  logic               wr_half;   // 0: high half pending, 1: low half pending
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        rd_idx;
  logic               rd_half;   // 0: expecting high half, 1: expecting low half
  logic [15:0]        hi_half;
  logic [31:0]        wr_word;
  logic [31:0]        rd_expect;
  logic               last_wr;
  logic               last_rd;
  logic               word_bad;
  logic               start_take;
  logic               rd_mismatch;

  assign wr_word   = base + {16'h0000, wr_idx};
  assign rd_expect = base + {16'h0000, rd_idx};

  assign wr_valid = (state == WRITE);
  assign rd_en    = (state == READ);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  // Gated so that wr_data reads 0 whenever no write is offered.
  assign wr_data  = (state != WRITE) ? 16'h0000 :
                    (wr_half ? wr_word[15:0] : wr_word[31:16]);

  assign last_wr     = (state == WRITE) && wr_ready && wr_half && (wr_idx == LAST_IDX);
  assign last_rd     = (state == READ) && rd_valid && rd_half && (rd_idx == LAST_IDX);
  assign word_bad    = ({hi_half, rd_data} != rd_expect);
  assign start_take  = (state == IDLE) && start && !abort;
  // Low half of a word accepted and the rebuilt word is wrong.
  assign rd_mismatch = (state == READ) && rd_valid && rd_half && !abort && word_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = WRITE;
        WRITE:   if (last_wr) state_next = (GAP_CYC == 0) ? READ : GAP;
        GAP:     if (gap_cnt == GAP_LAST) state_next = READ;
        READ:    if (last_rd) state_next = DONE;
        DONE:    state_next = loop ? WRITE : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base     <= SEED;
      wr_idx   <= 16'h0000;
      wr_half  <= 1'b0;
      gap_cnt  <= '0;
      rd_idx   <= 16'h0000;
      rd_half  <= 1'b0;
      hi_half  <= 16'h0000;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      pass_cnt <= 16'h0000;
      chk_data <= 16'h0000;
      chk_wren <= 1'b0;
    end else begin
      chk_data <= rd_data;
      chk_wren <= rd_valid && (state == READ);
      // On abort every counter and flag simply holds; a half-received
      // word is dropped because the next start re-arms rd_half.
      if (!abort) begin
        case (state)
          IDLE: begin
            if (start) begin
              err_cnt  <= '0;
              err_flag <= 1'b0;
              pass_cnt <= 16'h0000;
              base     <= SEED;
              wr_idx   <= 16'h0000;
              wr_half  <= 1'b0;
            end
          end
          WRITE: begin
            if (wr_ready) begin
              wr_half <= ~wr_half;
              if (wr_half) begin
                wr_idx <= wr_idx + 16'd1;
              end
            end
            if (last_wr) begin
              gap_cnt <= '0;
              rd_idx  <= 16'h0000;
              rd_half <= 1'b0;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
          READ: begin
            if (rd_valid) begin
              rd_half <= ~rd_half;
              if (!rd_half) begin
                hi_half <= rd_data;
              end else begin
                rd_idx <= rd_idx + 16'd1;
                if (word_bad) begin
                  err_flag <= 1'b1;
                  if (err_cnt != {ERR_W{1'b1}}) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                  end
                end
              end
            end
          end
          DONE: begin
            pass_cnt <= pass_cnt + 16'd1;
            base     <= base + WORDS32;
            wr_idx   <= 16'h0000;
            wr_half  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STREAM_SEQ_FIRST_ERR_EN
  logic [15:0] first_idx_reg;
  logic [31:0] first_word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_idx_reg  <= 16'h0000;
      first_word_reg <= 32'h0000_0000;
    end else if (start_take) begin
      first_idx_reg  <= 16'h0000;
      first_word_reg <= 32'h0000_0000;
    end else if (rd_mismatch && !err_flag) begin
      // err_flag is cleared only by start, so this fires once per test.
      first_idx_reg  <= rd_idx;
      first_word_reg <= {hi_half, rd_data};
    end
  end

  assign first_err_idx  = first_idx_reg;
  assign first_err_word = first_word_reg;
`else
  logic unused_capture;
  assign unused_capture = start_take ^ rd_mismatch;
  assign first_err_idx  = 16'h0000;
  assign first_err_word = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_stream_test_seq.sv
// Testbench for stream_test_seq. Two instances run side by side:
// instance 0 with SEED=0 and a 3-cycle gap, and instance 1 with
// SEED=0000_FFFE and no gap. Both use WORDS=4. The written halves are
// looped back on the read side, with optional corruption of one word.
// A pass/word-level reference model predicts every output on every cycle.
module tb_stream_test_seq;
  localparam int NI = 2;
  localparam int W  = 4;
  localparam logic [31:0] SEED0 = 32'h0000_0000;
  localparam logic [31:0] SEED1 = 32'h0000_FFFE;
  localparam int GAP0 = 3;
  localparam int GAP1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_ready;
  logic start [NI];
  logic loop [NI];
  logic abort [NI];
  logic [15:0] wr_data [NI];
  logic wr_valid [NI];
  logic rd_en [NI];
  logic [15:0] rd_data [NI];
  logic rd_valid [NI];
  logic [15:0] chk_data [NI];
  logic chk_wren [NI];
  logic busy [NI];
  logic done [NI];
  logic [15:0] pass_cnt [NI];
  logic [15:0] err_cnt [NI];
  logic err_flag [NI];
  logic [15:0] first_err_idx [NI];
  logic [31:0] first_err_word [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      stream_test_seq #(
        .WORDS(W),
        .SEED((gi == 0) ? SEED0 : SEED1),
        .GAP_CYC((gi == 0) ? GAP0 : GAP1),
        .ERR_W(16)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start[gi]), .loop(loop[gi]), .abort(abort[gi]),
        .wr_data(wr_data[gi]), .wr_valid(wr_valid[gi]), .wr_ready(wr_ready),
        .rd_en(rd_en[gi]), .rd_data(rd_data[gi]), .rd_valid(rd_valid[gi]),
        .chk_data(chk_data[gi]), .chk_wren(chk_wren[gi]), .busy(busy[gi]), .done(done[gi]),
        .pass_cnt(pass_cnt[gi]), .err_cnt(err_cnt[gi]), .err_flag(err_flag[gi]),
        .first_err_idx(first_err_idx[gi]), .first_err_word(first_err_word[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 write, 2 gap, 3 read, 4 done.
  int          ph [NI];
  logic [31:0] mbase [NI];
  int          nwr [NI];
  int          gleft [NI];
  int          nrd [NI];
  logic [15:0] mhi [NI];
  int          merr [NI];
  logic        mflag [NI];
  logic [15:0] mpass [NI];
  logic [15:0] mfidx [NI];
  logic [31:0] mfword [NI];
  logic [15:0] mchkd [NI];
  logic        mchkw [NI];

  logic [15:0] mem [NI][2*W];
  logic [15:0] xlog [NI][64];
  int          xn [NI];
  int          done_n [NI];
  int          rdp [NI];
  logic        abort_arm [NI];
  logic        abort_prev [NI];
  logic [15:0] err_at_abort [NI];
  int corrupt_idx = -1;
  int rdy_mode = 0;
  int loop_target = 0;
  int cyc = 0;

  logic [15:0] exp0 [8];
  logic [15:0] exp1 [8];

  function automatic logic [31:0] seed_of(input int i);
    return (i == 0) ? SEED0 : SEED1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Model update on the active edge, from the inputs that were set up at the
  // previous falling edge.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [31:0] w;
      w = 32'h0;
      if (!rst_n) begin
        ph[i] = 0; mbase[i] = seed_of(i); nwr[i] = 0; gleft[i] = 0; nrd[i] = 0;
        mhi[i] = 16'h0; merr[i] = 0; mflag[i] = 1'b0; mpass[i] = 16'h0;
        mfidx[i] = 16'h0; mfword[i] = 32'h0; mchkd[i] = 16'h0; mchkw[i] = 1'b0;
      end else begin
        if (wr_valid[i] === 1'b1 && wr_ready && xn[i] < 64) begin
          xlog[i][xn[i]] = wr_data[i];
          xn[i]++;
        end
        if (ph[i] == 1 && wr_ready && !abort[i]) mem[i][nwr[i]] = wr_data[i];
        mchkd[i] = rd_data[i];
        mchkw[i] = rd_valid[i] && (ph[i] == 3);
        if (abort[i]) begin
          ph[i] = 0;
        end else begin
          case (ph[i])
            0: if (start[i]) begin
                 merr[i] = 0; mflag[i] = 1'b0; mpass[i] = 16'h0; mbase[i] = seed_of(i);
                 nwr[i] = 0; mfidx[i] = 16'h0; mfword[i] = 32'h0; ph[i] = 1;
               end
            1: if (wr_ready) begin
                 nwr[i]++;
                 if (nwr[i] == 2 * W) begin
                   nrd[i] = 0;
                   gleft[i] = gap_of(i);
                   ph[i] = (gleft[i] == 0) ? 3 : 2;
                 end
               end
            2: begin
                 gleft[i]--;
                 if (gleft[i] == 0) ph[i] = 3;
               end
            3: if (rd_valid[i]) begin
                 if (nrd[i] % 2 == 0) begin
                   mhi[i] = rd_data[i];
                 end else begin
                   w = {mhi[i], rd_data[i]};
                   if (w != mbase[i] + 32'(nrd[i] / 2)) begin
                     if (!mflag[i]) begin
                       mfidx[i] = 16'(nrd[i] / 2);
                       mfword[i] = w;
                     end
                     mflag[i] = 1'b1;
                     if (merr[i] < 65535) merr[i]++;
                   end
                 end
                 nrd[i]++;
                 if (nrd[i] == 2 * W) ph[i] = 4;
               end
            4: begin
                 mpass[i] = mpass[i] + 16'd1;
                 mbase[i] = mbase[i] + 32'(W);
                 if (loop[i]) begin
                   nwr[i] = 0;
                   ph[i] = 1;
                 end else begin
                   ph[i] = 0;
                 end
               end
            default: ;
          endcase
        end
      end
    end
  end

  // Compare every output against the model, then drive the next inputs.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      logic [31:0] ew;
      ew = mbase[i] + 32'(nwr[i] / 2);
      chk("wr_valid", i, 32'(wr_valid[i]), 32'(ph[i] == 1));
      if (ph[i] == 1) chk("wr_data", i, 32'(wr_data[i]), (nwr[i] % 2 == 0) ? 32'(ew[31:16]) : 32'(ew[15:0]));
      chk("rd_en", i, 32'(rd_en[i]), 32'(ph[i] == 3));
      chk("busy", i, 32'(busy[i]), 32'(ph[i] != 0));
      chk("done", i, 32'(done[i]), 32'(ph[i] == 4));
      chk("pass_cnt", i, 32'(pass_cnt[i]), 32'(mpass[i]));
      chk("err_cnt", i, 32'(err_cnt[i]), 32'(merr[i]));
      chk("err_flag", i, 32'(err_flag[i]), 32'(mflag[i]));
      chk("chk_wren", i, 32'(chk_wren[i]), 32'(mchkw[i]));
      chk("chk_data", i, 32'(chk_data[i]), 32'(mchkd[i]));
`ifdef STREAM_SEQ_FIRST_ERR_EN
      chk("first_err_idx", i, 32'(first_err_idx[i]), 32'(mfidx[i]));
      chk("first_err_word", i, first_err_word[i], mfword[i]);
`else
      chk("first_err_idx", i, 32'(first_err_idx[i]), 32'h0);
      chk("first_err_word", i, first_err_word[i], 32'h0);
`endif
      if (abort_prev[i]) begin
        chk("abort_busy", i, 32'(busy[i]), 32'h0);
        chk("abort_rd_en", i, 32'(rd_en[i]), 32'h0);
        chk("abort_err_hold", i, 32'(err_cnt[i]), 32'(err_at_abort[i]));
        abort_prev[i] = 1'b0;
      end
      if (done[i] === 1'b1) begin
        done_n[i]++;
        $display("inst%0d pass %0d done: pass_cnt=%0d err_cnt=%0d", i, done_n[i], pass_cnt[i], err_cnt[i]);
      end

      loop[i] = (done_n[i] < loop_target);
      abort[i] = 1'b0;
      if (abort_arm[i] && ph[i] == 3 && nrd[i] == 5) begin
        abort[i] = 1'b1;
        abort_arm[i] = 1'b0;
        abort_prev[i] = 1'b1;
        err_at_abort[i] = err_cnt[i];
      end
      if (abort[i]) begin
        rd_valid[i] = 1'b0;
        rd_data[i] = 16'($urandom);
      end else if (rd_en[i] === 1'b1) begin
        if (rdp[i] < 2 * W && $urandom_range(0, 3) != 0) begin
          rd_valid[i] = 1'b1;
          if (rdp[i] / 2 == corrupt_idx) rd_data[i] = (rdp[i] % 2 == 0) ? 16'hDEAD : 16'hBEEF;
          else rd_data[i] = mem[i][rdp[i]];
          rdp[i]++;
        end else begin
          rd_valid[i] = 1'b0;
          rd_data[i] = 16'($urandom);
        end
      end else begin
        rdp[i] = 0;
        rd_valid[i] = 1'($urandom_range(0, 1));
        rd_data[i] = 16'($urandom);
      end
    end
    case (rdy_mode)
      1:       wr_ready = (cyc % 2 == 0);
      2:       wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = 1'b1;
    endcase
  end

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      xn[i] = 0;
      done_n[i] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    for (int i = 0; i < NI; i++) start[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 0, 32'(n < budget), 32'h1);
  endtask

  task automatic check_seq(input string name);
    for (int k = 0; k < 8; k++) begin
      chk(name, 0, 32'(xlog[0][k]), 32'(exp0[k]));
      chk(name, 1, 32'(xlog[1][k]), 32'(exp1[k]));
    end
  endtask

  initial begin
    exp0 = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0003};
    exp1 = '{16'h0000, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0001};
    wr_ready = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; loop[i] = 1'b0; abort[i] = 1'b0;
      rd_valid[i] = 1'b0; rd_data[i] = 16'h0;
      abort_arm[i] = 1'b0; abort_prev[i] = 1'b0; err_at_abort[i] = 16'h0;
      rdp[i] = 0; xn[i] = 0; done_n[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_busy", i, 32'(busy[i]), 32'h0);
      chk("reset_wr_valid", i, 32'(wr_valid[i]), 32'h0);
      chk("reset_wr_data", i, 32'(wr_data[i]), 32'h0);
      chk("reset_pass_cnt", i, 32'(pass_cnt[i]), 32'h0);
      chk("reset_err_cnt", i, 32'(err_cnt[i]), 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pass, always-ready write path, clean loopback.
    clear_logs();
    pulse_start();
    wait_idle(500);
    check_seq("t1_write_seq");
    for (int i = 0; i < NI; i++) begin
      chk("t1_xfers", i, 32'(xn[i]), 32'd8);
      chk("t1_done_pulses", i, 32'(done_n[i]), 32'd1);
      chk("t1_pass_cnt", i, 32'(pass_cnt[i]), 32'd1);
      chk("t1_err_cnt", i, 32'(err_cnt[i]), 32'd0);
    end

    // wr_ready alternating: same 8 halves, none repeated or skipped.
    rdy_mode = 1;
    clear_logs();
    pulse_start();
    wait_idle(500);
    check_seq("t2_toggle_seq");
    for (int i = 0; i < NI; i++) chk("t2_xfers", i, 32'(xn[i]), 32'd8);

    // Word 2 read back as DEADBEEF.
    rdy_mode = 2;
    corrupt_idx = 2;
    clear_logs();
    pulse_start();
    wait_idle(500);
    for (int i = 0; i < NI; i++) begin
      chk("t3_err_cnt", i, 32'(err_cnt[i]), 32'd1);
      chk("t3_err_flag", i, 32'(err_flag[i]), 32'd1);
      chk("t3_model_err", i, 32'(merr[i]), 32'd1);
`ifdef STREAM_SEQ_FIRST_ERR_EN
      chk("t3_first_idx", i, 32'(first_err_idx[i]), 32'd2);
      chk("t3_first_word", i, first_err_word[i], 32'hDEAD_BEEF);
`endif
    end

    // Three looped passes; err state cleared by the new start.
    corrupt_idx = -1;
    loop_target = 3;
    clear_logs();
    pulse_start();
    wait_idle(3000);
    loop_target = 0;
    for (int i = 0; i < NI; i++) begin
      chk("t4_done_pulses", i, 32'(done_n[i]), 32'd3);
      chk("t4_pass_cnt", i, 32'(pass_cnt[i]), 32'd3);
      chk("t4_xfers", i, 32'(xn[i]), 32'd24);
      chk("t4_err_flag", i, 32'(err_flag[i]), 32'd0);
    end
    chk("t4_base_p1", 0, {16'(xlog[0][0]), 16'(xlog[0][1])}, 32'h0000_0000);
    chk("t4_base_p2", 0, {16'(xlog[0][8]), 16'(xlog[0][9])}, 32'h0000_0004);
    chk("t4_base_p3", 0, {16'(xlog[0][16]), 16'(xlog[0][17])}, 32'h0000_0008);
    chk("t4_base_p3", 1, {16'(xlog[1][16]), 16'(xlog[1][17])}, 32'h0001_0006);

    // Abort mid-read after the high half of word 2; word 0 corrupted.
    rdy_mode = 0;
    corrupt_idx = 0;
    for (int i = 0; i < NI; i++) abort_arm[i] = 1'b1;
    clear_logs();
    pulse_start();
    wait_idle(500);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("t5_abort_fired", i, 32'(abort_arm[i]), 32'd0);
      chk("t5_err_cnt", i, 32'(err_cnt[i]), 32'd1);
      chk("t5_err_flag", i, 32'(err_flag[i]), 32'd1);
      chk("t5_pass_cnt", i, 32'(pass_cnt[i]), 32'd0);
      chk("t5_done_pulses", i, 32'(done_n[i]), 32'd0);
`ifdef STREAM_SEQ_FIRST_ERR_EN
      chk("t5_first_idx", i, 32'(first_err_idx[i]), 32'd0);
      chk("t5_first_word", i, first_err_word[i], 32'hDEAD_BEEF);
`endif
    end

    // Restart after abort: counters cleared, pattern restarts at SEED.
    corrupt_idx = -1;
    clear_logs();
    pulse_start();
    for (int i = 0; i < NI; i++) begin
      chk("t6_err_cleared", i, 32'(err_cnt[i]), 32'd0);
      chk("t6_flag_cleared", i, 32'(err_flag[i]), 32'd0);
      chk("t6_pass_cleared", i, 32'(pass_cnt[i]), 32'd0);
      chk("t6_wr_valid", i, 32'(wr_valid[i]), 32'd1);
      chk("t6_first_half", i, 32'(wr_data[i]), 32'h0000);
`ifdef STREAM_SEQ_FIRST_ERR_EN
      chk("t6_first_idx_cleared", i, 32'(first_err_idx[i]), 32'd0);
      chk("t6_first_word_cleared", i, first_err_word[i], 32'd0);
`endif
    end
    wait_idle(500);
    check_seq("t6_write_seq");
    for (int i = 0; i < NI; i++) begin
      chk("t6_pass_cnt", i, 32'(pass_cnt[i]), 32'd1);
      chk("t6_err_cnt", i, 32'(err_cnt[i]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_test_seq.md
Name: stream_test_seq

Overview:
- Sequencer for the SDRAM stream test.
- Writes a pass of incrementing 32-bit words to the SDRAM write path as 16-bit halves, high half first, then reads the pass back.
- Rebuilds each 32-bit word from the two read halves, compares it with the expected value and counts mismatches.
- Forwards every read half to the downstream stream error checker on chk_data/chk_wren.

Parameters:
- WORDS, 1024: 32-bit words per pass; range 1..65535.
- SEED, 32'h0000_0000: first pattern word after start.
- GAP_CYC, 16: idle cycles between the write phase and the read phase (write-path drain time); 0 is legal.
- ERR_W, 16: width of err_cnt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a test; honoured only in IDLE.
- loop  in  1  sampled in DONE: 1 starts another pass, 0 returns to IDLE.
- abort  in  1  synchronous stop; has priority over every other input.
- wr_data  out  16  write half-word.
- wr_valid  out  1  wr_data is valid.
- wr_ready  in  1  write path accepts the half.
- rd_en  out  1  high throughout READ; SDRAM read path may return data while it is high.
- rd_data  in  16  read half-word.
- rd_valid  in  1  rd_data is valid.
- chk_data  out  16  registered copy of rd_data.
- chk_wren  out  1  registered copy of (rd_valid && state==READ).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of each pass.
- pass_cnt  out  16  completed passes; wraps modulo 2^16.
- err_cnt  out  ERR_W  mismatched words; saturates at all-ones.
- err_flag  out  1  sticky; set on the first mismatch.
- first_err_idx  out  16  see Optional Feature.
- first_err_word  out  32  see Optional Feature.

Behaviour:
- Reset: state IDLE; every output 0; base=SEED; all internal counters 0.
- States: IDLE, WRITE, GAP, READ, DONE.
- IDLE -> WRITE on start. Same edge: err_cnt=0, err_flag=0, pass_cnt=0, base=SEED, wr_idx=0, half=HI.
- WRITE:
  - wr_valid=1. wr_data = (base+wr_idx)[31:16] when half=HI, [15:0] when half=LO.
  - A half transfers on wr_valid && wr_ready; wr_data is held stable while wr_ready=0.
  - After the LO transfer, wr_idx increments.
  - After 2*WORDS transfers: wr_valid drops on the next cycle and state goes to GAP.
- GAP:
  - Counts exactly GAP_CYC cycles, then READ. With GAP_CYC=0, WRITE goes straight to READ.
- READ:
  - rd_en=1. rd_valid is accepted every cycle, back-to-back.
  - The HI half is captured first. On the LO half, form {hi,lo} and compare with base+rd_idx (arithmetic modulo 2^32).
  - On mismatch: err_cnt increments (saturating) and err_flag=1.
  - After 2*WORDS halves -> DONE; rd_en=0 in DONE.
  - rd_valid outside READ is ignored: not counted, not forwarded.
- DONE (exactly 1 cycle):
  - done=1, pass_cnt+1, base=base+WORDS (mod 2^32).
  - Next state WRITE if loop=1, otherwise IDLE.
  - err_cnt and err_flag are not cleared between looped passes.
- abort (any state): next state IDLE; wr_valid, rd_en and done drop; a partial word pair is discarded. Counters and err flags hold their values.
- start while busy: ignored.
- Latency: chk_data/chk_wren trail rd_data/rd_valid by 1 cycle. err_cnt updates 1 cycle after the LO half is accepted.
- The final word's error count is committed before DONE is entered.

Optional Feature:
- Macro: STREAM_SEQ_FIRST_ERR_EN.
- Defined:
  - first_err_idx and first_err_word latch rd_idx and the received {hi,lo} of the first mismatch since start.
  - They are held until the next start.
  - They are cleared by reset and by start.
- Undefined: both ports are constant 0 and no capture registers are built.

Test Plan:
- WORDS=4, SEED=0, wr_ready=1, rd_data loopback.
  -> Write sequence 0000,0000,0000,0001,0000,0002,0000,0003.
  -> done after the read phase; err_cnt=0, pass_cnt=1.
- SEED=32'h0000_FFFE, WORDS=4, loopback.
  -> Written words FFFE, FFFF, 0001_0000, 0001_0001 (carry into the high half).
  -> err_cnt=0.
- wr_ready toggling 1010…
  -> wr_data holds while wr_ready=0; exactly 8 transfers; no half repeated or skipped.
- Loopback with word 2 corrupted to 32'hDEAD_BEEF.
  -> err_cnt=1, err_flag=1.
  -> With the macro: first_err_idx=2, first_err_word=DEADBEEF.
- loop=1 for 3 passes, WORDS=4, SEED=0.
  -> Pass bases 0, 4, 8; pass_cnt=3; three done pulses.
- abort asserted mid-READ after a HI half.
  -> IDLE next cycle; rd_en=0; err_cnt unchanged.
  -> A new start restarts from SEED with counters cleared.
